cdb_arbiter: RTL and testbench

Common Data Bus arbiter directly downstream of the execute stage. Each cycle it selects at most one completed functional-unit result and returns a same-cycle `ack` to the winning FU, so the FU can retire its output register and the execute stage can form its branch packet. The winner is registered and broadcast on the CDB one cycle later to the RS, ROB and map table. Base policy is fixed priority with FU 1 highest; an optional starvation guard bounds the wait of lower-priority units.

---
 rtl/cdb_arbiter_if.sv | 31 +++
 rtl/cdb_arbiter.sv | 94 +++++++++
 tb/tb_cdb_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbiter bus bundle: per-FU completion requests in,
// same-cycle ack and the registered CDB broadcast out.
// master = FU/consumer side, slave = arbiter side.
interface cdb_arbiter_if #(
  parameter int NUM_FU    = 6,
  parameter int ROB_TAG_W = 5,
  parameter int PREG_W    = 6,
  parameter int XLEN      = 32
);
  logic [NUM_FU:0]                req_valid;
  logic [NUM_FU:0][ROB_TAG_W-1:0] req_rob_tag;
  logic [NUM_FU:0][PREG_W-1:0]    req_preg;
  logic [NUM_FU:0][XLEN-1:0]      req_value;
  logic [NUM_FU:0]                squash_mask;
  logic [NUM_FU:0]                ack;
  logic                           cdb_valid;
  logic [ROB_TAG_W-1:0]           cdb_rob_tag;
  logic [PREG_W-1:0]              cdb_preg;
  logic [XLEN-1:0]                cdb_value;
  logic [2:0]                     cdb_fu_idx;

  modport master (
    output req_valid, req_rob_tag, req_preg, req_value, squash_mask,
    input  ack, cdb_valid, cdb_rob_tag, cdb_preg, cdb_value, cdb_fu_idx
  );

  modport slave (
    input  req_valid, req_rob_tag, req_preg, req_value, squash_mask,
    output ack, cdb_valid, cdb_rob_tag, cdb_preg, cdb_value, cdb_fu_idx
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter. Picks at most one eligible FU result per cycle
// (fixed priority, FU 1 highest), acks it combinationally and broadcasts it
// on the CDB one cycle later.
// Optional starvation guard: define CDB_STARVE_GUARD_EN to add per-FU wait
// counters that force a grant after STARVE_LIMIT cycles of losing.
module cdb_arbiter #(
  parameter int NUM_FU       = 6,
  parameter int ROB_TAG_W    = 5,
  parameter int PREG_W       = 6,
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clock,
  input  logic          reset,
  cdb_arbiter_if.slave  bus
);

  logic [NUM_FU:0] elig;   // valid, not squashed, real ROB tag
  logic [NUM_FU:0] pick;   // candidate set the priority encoder scans
  logic [NUM_FU:0] grant;  // one-hot winner (ungated by reset)
  logic [2:0]      win_idx;
  logic            any;

  // Eligibility: index 0 is reserved and never participates.
  always_comb begin
    elig = '0;
    for (int i = 1; i <= NUM_FU; i++)
      elig[i] = bus.req_valid[i] & ~bus.squash_mask[i] & (bus.req_rob_tag[i] != '0);
  end

`ifdef CDB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [NUM_FU:0] starved;

  assign starved[0] = 1'b0;

  for (genvar g = 1; g <= NUM_FU; g++) begin : g_guard
    logic [CNT_W-1:0] cnt;
    assign starved[g] = elig[g] & (cnt == CNT_W'(STARVE_LIMIT));
    // Count edges spent eligible but losing; any win or drop clears it.
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        cnt <= '0;
      else if (elig[g] & ~grant[g]) begin
        if (cnt != CNT_W'(STARVE_LIMIT))
          cnt <= cnt + CNT_W'(1);
      end else
        cnt <= '0;
    end
  end

  // A starved FU pre-empts fixed priority; lowest starved index among them.
  assign pick = (|starved) ? starved : elig;
`else
  assign pick = elig;
`endif

  // Priority encoder: scan high to low so the lowest index wins.
  always_comb begin
    grant   = '0;
    win_idx = '0;
    for (int i = NUM_FU; i >= 1; i--) begin
      if (pick[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        win_idx  = 3'(i);
      end
    end
    any = |pick;
  end

  // No ack may escape while the block is held in reset.
  assign bus.ack = reset ? '0 : grant;

  // Broadcast register: load winner, or drop valid and hold the payload.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.cdb_valid   <= 1'b0;
      bus.cdb_rob_tag <= '0;
      bus.cdb_preg    <= '0;
      bus.cdb_value   <= '0;
      bus.cdb_fu_idx  <= '0;
    end else if (any) begin
      bus.cdb_valid   <= 1'b1;
      bus.cdb_rob_tag <= bus.req_rob_tag[win_idx];
      bus.cdb_preg    <= bus.req_preg[win_idx];
      bus.cdb_value   <= bus.req_value[win_idx];
      bus.cdb_fu_idx  <= win_idx;
    end else begin
      bus.cdb_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: table of single-cycle grant vectors plus hand
// sequences for multi-cycle cases; CDB payload checked through a queue of
// expected broadcasts pushed when each ack is expected.
module tb_cdb_arbiter;
  localparam int NUM_FU       = 6;
  localparam int ROB_TAG_W    = 5;
  localparam int PREG_W       = 6;
  localparam int XLEN         = 32;
  localparam int STARVE_LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .ROB_TAG_W(ROB_TAG_W), .PREG_W(PREG_W), .XLEN(XLEN)) bus ();

  cdb_arbiter #(
    .NUM_FU(NUM_FU), .ROB_TAG_W(ROB_TAG_W), .PREG_W(PREG_W),
    .XLEN(XLEN), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        valid;
    logic [4:0]  tag;
    logic [5:0]  preg;
    logic [31:0] value;
    logic [2:0]  idx;
  } bc_t;

  typedef struct {
    logic [6:0] v;
    logic [6:0] sq;
    logic [6:0] tz;
    logic [6:0] ack;
  } vec_t;

  bc_t  exp_q[$];
  bc_t  last;
  int   checks   = 0;
  int   failures = 0;

  logic [4:0]  tag_a   [1:NUM_FU];
  logic [5:0]  preg_a  [1:NUM_FU];
  logic [31:0] value_a [1:NUM_FU];

  task automatic set_payload(input int k, input logic [6:0] tz);
    for (int i = 1; i <= NUM_FU; i++) begin
      tag_a[i]   = tz[i] ? 5'd0 : 5'((k * 7 + i) % 31 + 1);
      preg_a[i]  = 6'((k * 5 + i * 3) % 64);
      value_a[i] = 32'hA5A5_0000 ^ 32'(k * 256 + i);
    end
  endtask

  task automatic drive(input logic [6:0] v, input logic [6:0] sq);
    bus.req_valid      = v;
    bus.squash_mask    = sq;
    bus.req_rob_tag[0] = '0;
    bus.req_preg[0]    = '0;
    bus.req_value[0]   = '0;
    for (int i = 1; i <= NUM_FU; i++) begin
      bus.req_rob_tag[i] = tag_a[i];
      bus.req_preg[i]    = preg_a[i];
      bus.req_value[i]   = value_a[i];
    end
  endtask

  task automatic reset_model();
    exp_q.delete();
    last = '0;
    exp_q.push_back(last);
  endtask

  task automatic check_zero_out(input string name, input logic [6:0] exp_ack);
    bc_t act;
    act = {bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_preg, bus.cdb_value, bus.cdb_fu_idx};
    checks++;
    if (act !== '0) begin
      failures++;
      $display("FAIL %s cdb: got %h want 0", name, act);
    end
    checks++;
    if (bus.ack !== exp_ack) begin
      failures++;
      $display("FAIL %s ack: got %b want %b", name, bus.ack, exp_ack);
    end
  endtask

  // One clock: check ack and this cycle's broadcast, then queue next broadcast.
  task automatic cycle(input string name, input logic [6:0] exp_ack);
    bc_t e, act;
    int  idx;
    @(negedge clock);
    checks++;
    if (bus.ack !== exp_ack) begin
      failures++;
      $display("FAIL %s ack: got %b want %b", name, bus.ack, exp_ack);
    end
    act = {bus.cdb_valid, bus.cdb_rob_tag, bus.cdb_preg, bus.cdb_value, bus.cdb_fu_idx};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s cdb: got %h want <no expectation queued>", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        failures++;
        $display("FAIL %s cdb: got v=%b tag=%0d preg=%0d val=%h idx=%0d want v=%b tag=%0d preg=%0d val=%h idx=%0d",
                 name, act.valid, act.tag, act.preg, act.value, act.idx,
                 e.valid, e.tag, e.preg, e.value, e.idx);
      end
    end
    idx = 0;
    for (int i = NUM_FU; i >= 1; i--) if (exp_ack[i]) idx = i;
    if (idx != 0) last = {1'b1, tag_a[idx], preg_a[idx], value_a[idx], 3'(idx)};
    else          last.valid = 1'b0;
    exp_q.push_back(last);
    @(posedge clock);
    #1;
  endtask

  vec_t tbl [10];

  initial begin
    tbl[0] = '{v: 7'b0000000, sq: 7'b0000000, tz: 7'b0000000, ack: 7'b0000000};
    tbl[1] = '{v: 7'b0001000, sq: 7'b0000000, tz: 7'b0000000, ack: 7'b0001000};
    tbl[2] = '{v: 7'b1111110, sq: 7'b0000000, tz: 7'b0000000, ack: 7'b0000010};
    tbl[3] = '{v: 7'b1010100, sq: 7'b0000100, tz: 7'b0000000, ack: 7'b0010000};
    tbl[4] = '{v: 7'b0000001, sq: 7'b0000000, tz: 7'b0000000, ack: 7'b0000000};
    tbl[5] = '{v: 7'b1000000, sq: 7'b0000000, tz: 7'b0000000, ack: 7'b1000000};
    tbl[6] = '{v: 7'b0100100, sq: 7'b0000000, tz: 7'b0000100, ack: 7'b0100000};
    tbl[7] = '{v: 7'b1111110, sq: 7'b1111110, tz: 7'b0000000, ack: 7'b0000000};
    tbl[8] = '{v: 7'b0110000, sq: 7'b0000000, tz: 7'b0000000, ack: 7'b0010000};
    tbl[9] = '{v: 7'b1100000, sq: 7'b0000000, tz: 7'b0100000, ack: 7'b1000000};

    // Reset state, with requests pending: ack must stay 0.
    set_payload(0, 7'b0);
    drive(7'b0111110, 7'b0);
    #2;
    check_zero_out("reset_state", 7'b0);
    @(posedge clock);
    #1;
    check_zero_out("reset_held", 7'b0);
    drive(7'b0, 7'b0);
    reset = 1'b0;
    reset_model();

    // Table vectors, back-to-back (also exercises 1/cycle throughput).
    for (int k = 0; k < 10; k++) begin
      set_payload(k + 1, tbl[k].tz);
      drive(tbl[k].v, tbl[k].sq);
      cycle($sformatf("vec%0d", k), tbl[k].ack);
    end
    drive(7'b0, 7'b0);
    cycle("vec_drain", 7'b0);

    // FU 3: tag 5, preg 9, value 0xDEAD; broadcast lasts one cycle.
    set_payload(20, 7'b0);
    tag_a[3] = 5'd5; preg_a[3] = 6'd9; value_a[3] = 32'h0000_DEAD;
    drive(7'b0001000, 7'b0);
    cycle("fu3_ack", 7'b0001000);
    drive(7'b0, 7'b0);
    cycle("fu3_bcast", 7'b0);
    cycle("fu3_gone", 7'b0);

    // FUs 1, 2, 5 together; each drops on its ack.
    set_payload(21, 7'b0);
    drive(7'b0100110, 7'b0);
    cycle("seq_fu1", 7'b0000010);
    drive(7'b0100100, 7'b0);
    cycle("seq_fu2", 7'b0000100);
    drive(7'b0100000, 7'b0);
    cycle("seq_fu5", 7'b0100000);
    drive(7'b0, 7'b0);
    cycle("seq_last", 7'b0);
    cycle("seq_idle", 7'b0);

    // Squashed FU 2 loses to FU 4 and is never broadcast.
    set_payload(22, 7'b0);
    drive(7'b0010100, 7'b0000100);
    cycle("squash_fu4", 7'b0010000);
    drive(7'b0000100, 7'b0000100);
    cycle("squash_only", 7'b0);
    drive(7'b0, 7'b0);
    cycle("squash_drain", 7'b0);
    cycle("squash_idle", 7'b0);

    // Tag 0 is never eligible.
    set_payload(23, 7'b0000010);
    drive(7'b0000010, 7'b0);
    cycle("tag0_req", 7'b0);
    drive(7'b0, 7'b0);
    cycle("tag0_after", 7'b0);

    // FU 1 keeps requesting while FU 6 holds its request.
    set_payload(24, 7'b0);
    drive(7'b1000010, 7'b0);
`ifdef CDB_STARVE_GUARD_EN
    for (int c = 0; c < STARVE_LIMIT; c++)
      cycle($sformatf("starve_c%0d", c), 7'b0000010);
    cycle("starve_forced", 7'b1000000);
    drive(7'b0000010, 7'b0);
    cycle("starve_fu1_again", 7'b0000010);
`else
    for (int c = 0; c < 8; c++)
      cycle($sformatf("starve_c%0d", c), 7'b0000010);
    drive(7'b1000000, 7'b0);
    cycle("starve_fu6_free", 7'b1000000);
`endif
    drive(7'b0, 7'b0);
    cycle("starve_drain", 7'b0);
    cycle("starve_idle", 7'b0);

    // Asynchronous reset between edges while a broadcast is live.
    set_payload(25, 7'b0);
    drive(7'b0000100, 7'b0);
    cycle("rst_pre_ack", 7'b0000100);
    checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_rob_tag !== tag_a[2]) begin
      failures++;
      $display("FAIL rst_pre_bcast: got v=%b tag=%0d want v=1 tag=%0d",
               bus.cdb_valid, bus.cdb_rob_tag, tag_a[2]);
    end
    #1 reset = 1'b1;
    #1 check_zero_out("rst_async", 7'b0);
    #1 reset = 1'b0;
    drive(7'b0, 7'b0);
    reset_model();
    cycle("rst_post", 7'b0);
    set_payload(26, 7'b0);
    drive(7'b0100000, 7'b0);
    cycle("rst_resume", 7'b0100000);
    drive(7'b0, 7'b0);
    cycle("rst_resume_bc", 7'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
